ns_rr_arb: RTL and testbench

//   Round-robin arbiter sharing one resource among N requesters. Built on ns_prio_enc
//   (MSB-first priority encoder); fairness by masking off requesters at or above the last grant.

---
 rtl/ns_arb_pkg.sv | 11 +
 rtl/ns_prio_enc.sv | 21 ++
 rtl/ns_rr_arb.sv | 99 +++++++++
 tb/tb_ns_rr_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ns_arb_pkg.sv
// Shared types and sizing helpers for the ns_* round-robin arbiter.
package ns_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_st_e;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ns_prio_enc.sv
// MSB-first priority encoder: idx is the highest set bit of x, meaningful only when vld.
module ns_prio_enc
    import ns_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    output logic [IW-1:0]    idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) idx = IW'(i);
        end
        vld = |x;
    end

endmodule

// File: rtl/ns_rr_arb.sv
// Round-robin arbiter with registered one-hot grant, owner release and optional hold timeout.
module ns_rr_arb
    import ns_arb_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int TMO = 256,
    localparam int IW  = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          rel,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_vld,
    output logic          tmo_err
);

    localparam int            CW       = idx_w(TMO + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TMO > 0) ? TMO - 1 : 0);
    localparam logic [N-1:0]  ONE      = N'(1);

    arb_st_e       state_reg;
    logic [N-1:0]  gnt_reg;
    logic [IW-1:0] gnt_id_reg;
    logic [IW-1:0] ptr_reg;
    logic [CW-1:0] cnt_reg;
    logic          tmo_err_reg;

    logic [N-1:0]  masked;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] u_idx;
    logic [IW-1:0] pick;
    logic          m_vld;
    logic          any_req;
    logic          tmo_hit;
    logic          release_now;

    // Only requesters strictly below the last winner compete first.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i < int'(ptr_reg));
        end
    end

    ns_prio_enc #(.WIDTH(N)) u_enc_masked (
        .x   (masked),
        .idx (m_idx),
        .vld (m_vld)
    );

    ns_prio_enc #(.WIDTH(N)) u_enc_all (
        .x   (req),
        .idx (u_idx),
        .vld (any_req)
    );

    always_comb begin
        pick        = m_vld ? m_idx : u_idx;
        tmo_hit     = (TMO != 0) && (state_reg == BUSY) && (cnt_reg == CNT_LAST) && !rel;
        release_now = (state_reg == BUSY) && (rel || tmo_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            tmo_err_reg <= 1'b0;
        end else begin
            tmo_err_reg <= 1'b0;
            if ((state_reg == IDLE) || release_now) begin
                if (any_req) begin
                    state_reg  <= BUSY;
                    gnt_reg    <= ONE << pick;
                    gnt_id_reg <= pick;
                    ptr_reg    <= pick;
                    cnt_reg    <= '0;
                end else begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                end
                // A release in the same cycle as the timeout suppresses the error.
                tmo_err_reg <= tmo_hit;
            end else if (cnt_reg != '1) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign gnt_vld = |gnt_reg;
    assign tmo_err = tmo_err_reg;

endmodule

// File: tb/tb_ns_rr_arb.sv
// Directed vectors, reset corner cases and a randomized run against a round-robin reference model.
module tb_ns_rr_arb;

    localparam int N   = 8;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         rel = 1'b0;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         gnt_vld;
    logic         tmo_err;

    int checks = 0;
    int errors = 0;

    ns_rr_arb #(.N(N), .TMO(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .tmo_err (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rel;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       tmo;
    } vec_t;

    vec_t tv[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Reference model: owner (-1 = none), last winner, cycles held so far.
    int   m_owner;
    int   m_ptr;
    int   m_hold;
    logic m_tmo;

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (p - k + N) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rl, output bit newg);
        bit timed;
        newg  = 1'b0;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = rr_pick(r, m_ptr);
                m_ptr = m_owner; m_hold = 0; newg = 1'b1;
            end
        end else begin
            timed = (m_hold == TMO - 1) && !rl;
            if (rl || timed) begin
                m_tmo = timed;
                if (r != 0) begin
                    m_owner = rr_pick(r, m_ptr);
                    m_ptr = m_owner; m_hold = 0; newg = 1'b1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    initial begin
        int   waits[N];
        bit   newg;
        bit   last_newg;
        logic [7:0] prev_req;

        //              req    rel   gnt    id    tmo
        tv[0]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b0};  // first grant: highest request
        tv[1]  = '{8'h24, 1'b1, 8'h04, 3'd2, 1'b0};
        tv[2]  = '{8'h24, 1'b1, 8'h20, 3'd5, 1'b0};  // wrap back to 5
        tv[3]  = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b0};
        tv[4]  = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b0};  // sole requester regranted
        tv[5]  = '{8'h00, 1'b0, 8'h01, 3'd0, 1'b0};  // held with req dropped
        tv[6]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};  // release to idle
        tv[7]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tv[8]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b0};
        tv[9]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b0};
        tv[10] = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b0};
        tv[11] = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b0};
        tv[12] = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b1};  // timeout regrant
        tv[13] = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b0};
        tv[14] = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b0};
        tv[15] = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b0};
        tv[16] = '{8'h24, 1'b1, 8'h20, 3'd5, 1'b0};  // rel on the timeout cycle wins
        tv[17] = '{8'h00, 1'b0, 8'h20, 3'd5, 1'b0};
        tv[18] = '{8'h00, 1'b0, 8'h20, 3'd5, 1'b0};
        tv[19] = '{8'h00, 1'b0, 8'h20, 3'd5, 1'b0};
        tv[20] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b1};  // timeout with no requests
        tv[21] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};

        // Outputs stay zero while reset is held, even with requests present.
        req = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_vld", gnt_vld, 0);
            chk("rst_id", gnt_id, 0);
            chk("rst_tmo", tmo_err, 0);
        end
        req = 8'h00;
        rst_n = 1'b1;
        $display("reset released");

        for (int v = 0; v < 22; v++) begin
            req = tv[v].req;
            rel = tv[v].rel;
            @(negedge clk);
            $display("vec %0d req=%h rel=%0b -> gnt=%h id=%0d vld=%0b tmo=%0b",
                     v, tv[v].req, tv[v].rel, gnt, gnt_id, gnt_vld, tmo_err);
            chk($sformatf("vec%0d_gnt", v), gnt, tv[v].gnt);
            chk($sformatf("vec%0d_vld", v), gnt_vld, (tv[v].gnt != 0));
            chk($sformatf("vec%0d_tmo", v), tmo_err, tv[v].tmo);
            if (tv[v].gnt != 0) chk($sformatf("vec%0d_id", v), gnt_id, tv[v].id);
        end
        rel = 1'b0;

        // Asynchronous reset mid-grant, then first grant again starts from the top.
        req = 8'h24;
        @(negedge clk);
        chk("pre_arst_vld", gnt_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-grant -> gnt=%h vld=%0b", gnt, gnt_vld);
        chk("arst_gnt", gnt, 0);
        chk("arst_vld", gnt_vld, 0);
        chk("arst_id", gnt_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h81;
        @(negedge clk);
        $display("post-reset req=81 -> gnt=%h id=%0d", gnt, gnt_id);
        chk("post_rst_gnt", gnt, 8'h80);
        chk("post_rst_id", gnt_id, 7);

        // Randomized run against the model, with a starvation bound on every grant.
        rst_n = 1'b0;
        req = 8'h00;
        rel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) waits[i] = 0;
        last_newg = 1'b0;
        prev_req = 8'h00;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int exp_gnt;
            int maxw;
            exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
            chk("rnd_gnt", gnt, exp_gnt);
            chk("rnd_vld", gnt_vld, (m_owner >= 0));
            chk("rnd_tmo", tmo_err, m_tmo);
            chk("rnd_onehot", $onehot0(gnt), 1);
            if (m_owner >= 0) chk("rnd_id", gnt_id, m_owner);

            for (int i = 0; i < N; i++) if (!prev_req[i]) waits[i] = 0;
            if (last_newg) begin
                maxw = 0;
                for (int i = 0; i < N; i++) begin
                    if (prev_req[i]) begin
                        if (i == int'(gnt_id)) waits[i] = 0;
                        else waits[i]++;
                    end
                    if (waits[i] > maxw) maxw = waits[i];
                end
                checks++;
                if (maxw > N) begin
                    errors++;
                    $display("FAIL starve cyc=%0d act_wait=%0d max_allowed=%0d", cyc, maxw, N);
                end
            end

            if ($urandom_range(3) == 0) begin
                logic [31:0] r;
                r = $urandom;
                req = r[7:0] & (r[8] ? r[15:8] : 8'hFF);
            end
            rel = (m_owner >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            model_step(req, rel, newg);
            last_newg = newg;
            prev_req = req;
            @(negedge clk);
        end
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
